// File: rtl/sigsrc_pkg.sv
// Shared constants and types for the correlator signal-source path
// (sigreplay capture/replay front end and sigsource).
package sigsrc_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_COUNT = 15;
  localparam int DEF_CBITS = 4;
  localparam int DEF_TRATE = 6;
  localparam int DEF_TBITS = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } replay_state_e;

endpackage

// File: rtl/sigreplay_ram.sv
// Simple dual-port sample store for both ping-pong banks: synchronous write,
// registered read. Addressed as {bank, cnt}, so the array is rounded up to a power of two.
module sigreplay_ram
  import sigsrc_pkg::*;
#(
  parameter int DW = 2 * DEF_WIDTH,
  parameter int AW = DEF_CBITS + 1
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sigreplay.sv
// Captures COUNT-sample I/Q blocks into a ping-pong buffer and replays each
// full block TRATE times as one framed, gap-free stream for the time-multiplexed MUX.
module sigreplay
  import sigsrc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT,
  parameter int CBITS = DEF_CBITS,
  parameter int TRATE = DEF_TRATE,
  parameter int TBITS = DEF_TBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [TBITS-1:0] taddr_o,
  output logic [WIDTH-1:0] idata_o,
  output logic [WIDTH-1:0] qdata_o
);

  localparam int AW = CBITS + 1;
  localparam int DW = 2 * WIDTH;
  localparam logic [CBITS-1:0] CNT_LAST  = CBITS'(COUNT - 1);
  localparam logic [TBITS-1:0] PASS_LAST = TBITS'(TRATE - 1);

  logic [CBITS-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q, full_d;
  replay_state_e    state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [CBITS-1:0] rcnt_q, rcnt_d;
  logic [TBITS-1:0] pass_q, pass_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic [TBITS-1:0] s1_pass_q, s1_pass_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [TBITS-1:0] taddr_q, taddr_d;
  logic [WIDTH-1:0] idata_q, idata_d;
  logic [WIDTH-1:0] qdata_q, qdata_d;

  logic          accept;
  logic          cap_done;
  logic          rd_en;
  logic          frame_end;
  logic          other_full;
  logic          bank_release;
  logic [DW-1:0] ram_rdata;

  assign accept    = valid_i & ~full_q[wbank_q];
  assign cap_done  = accept & (wcnt_q == CNT_LAST);
  assign rd_en     = (state_q == ST_PLAY);
  assign frame_end = rd_en & (rcnt_q == CNT_LAST) & (pass_q == PASS_LAST);
  // A block finishing capture in the very cycle of the final read still counts,
  // so the next frame follows without a bubble.
  assign other_full = full_q[~rbank_q] | (cap_done & (wbank_q != rbank_q));

  sigreplay_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clock  (clock),
    .we_i   (accept),
    .waddr_i({wbank_q, wcnt_q}),
    .wdata_i({idata_i, qdata_i}),
    .re_i   (rd_en),
    .raddr_i({rbank_q, rcnt_q}),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    if (accept) begin
      if (cap_done) begin
        wcnt_d          = '0;
        wbank_d         = ~wbank_q;
        full_d[wbank_q] = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    if (bank_release) full_d[rbank_q] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    rbank_d      = rbank_q;
    rcnt_d       = rcnt_q;
    pass_d       = pass_q;
    bank_release = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = ST_PLAY;
          rcnt_d  = '0;
          pass_d  = '0;
        end
      end
      ST_PLAY: begin
        if (rcnt_q == CNT_LAST) begin
          rcnt_d = '0;
          if (pass_q == PASS_LAST) begin
            bank_release = 1'b1;
            rbank_d      = ~rbank_q;
            pass_d       = '0;
            if (!other_full) state_d = ST_IDLE;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Framing travels alongside the RAM read, then lands in the output register.
  always_comb begin
    s1_valid_d = rd_en;
    s1_first_d = rd_en & (rcnt_q == '0) & (pass_q == '0);
    s1_last_d  = frame_end;
    s1_pass_d  = pass_q;
    valid_d    = s1_valid_q;
    first_d    = s1_valid_q & s1_first_q;
    last_d     = s1_valid_q & s1_last_q;
    taddr_d    = taddr_q;
    idata_d    = idata_q;
    qdata_d    = qdata_q;
    if (s1_valid_q) begin
      taddr_d = s1_pass_q;
      idata_d = ram_rdata[DW-1:WIDTH];
      qdata_d = ram_rdata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      state_q    <= ST_IDLE;
      rbank_q    <= 1'b0;
      rcnt_q     <= '0;
      pass_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pass_q  <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      taddr_q    <= '0;
      idata_q    <= '0;
      qdata_q    <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      full_q     <= full_d;
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      rcnt_q     <= rcnt_d;
      pass_q     <= pass_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_pass_q  <= s1_pass_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      taddr_q    <= taddr_d;
      idata_q    <= idata_d;
      qdata_q    <= qdata_d;
    end
  end

  assign ready_o = ~full_q[wbank_q];
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign taddr_o = taddr_q;
  assign idata_o = idata_q;
  assign qdata_o = qdata_q;

endmodule
